// File: rtl/tea_iter_core.sv
// Iterative TEA block cipher engine: 64-bit block, 128-bit key, ROUNDS rounds
// with UNROLL rounds evaluated per enabled clock over a shared datapath.
module tea_iter_core #(
  parameter int          ROUNDS = 32,
  parameter int          UNROLL = 1,
  parameter logic [31:0] DELTA  = 32'h9E3779B9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ena,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          encrypt,
  input  logic [63:0]   in_block,
  input  logic [127:0]  key,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [63:0]   out_block,
  output logic          busy
);

  if (ROUNDS < 1 || UNROLL < 1 || (ROUNDS % UNROLL) != 0) begin : g_bad_cfg
    $error("tea_iter_core: ROUNDS must be >= 1 and a multiple of UNROLL");
  end

  localparam int            STEPS    = ROUNDS / UNROLL;
  localparam int            CW       = $clog2(STEPS) + 1;
  localparam logic [CW-1:0] LAST     = CW'(STEPS - 1);
  localparam logic [63:0]   SUM_PROD = 64'(DELTA) * 64'(ROUNDS);
  localparam logic [31:0]   SUM_DEC  = SUM_PROD[31:0];

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e         state_q, state_d;
  logic [31:0]    v0_q, v0_d, v1_q, v1_d, sum_q, sum_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [127:0]   key_q, key_d;
  logic           enc_q, enc_d;
  logic [63:0]    res_q, res_d;
  logic [31:0]    r0, r1, rs;

  function automatic logic [31:0] mix(input logic [31:0] v, input logic [31:0] s,
                                      input logic [31:0] ka, input logic [31:0] kb);
    return ((v << 4) + ka) ^ (v + s) ^ ((v >> 5) + kb);
  endfunction

  // Rounds chained combinationally; decrypt undoes the encrypt order exactly.
  always_comb begin
    r0 = v0_q;
    r1 = v1_q;
    rs = sum_q;
    for (int i = 0; i < UNROLL; i++) begin
      if (enc_q) begin
        rs = rs + DELTA;
        r0 = r0 + mix(r1, rs, key_q[127:96], key_q[95:64]);
        r1 = r1 + mix(r0, rs, key_q[63:32], key_q[31:0]);
      end else begin
        r1 = r1 - mix(r0, rs, key_q[63:32], key_q[31:0]);
        r0 = r0 - mix(r1, rs, key_q[127:96], key_q[95:64]);
        rs = rs - DELTA;
      end
    end
  end

  always_comb begin
    // NOTE: every next-state signal takes its held value first, so no path infers a latch.
    state_d = state_q;
    v0_d    = v0_q;
    v1_d    = v1_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    key_d   = key_q;
    enc_d   = enc_q;
    res_d   = res_q;
    unique case (state_q)
      IDLE: if (in_valid) begin
        v0_d    = in_block[63:32];
        v1_d    = in_block[31:0];
        key_d   = key;
        enc_d   = encrypt;
        sum_d   = encrypt ? 32'h0 : SUM_DEC;
        cnt_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        v0_d  = r0;
        v1_d  = r1;
        sum_d = rs;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          res_d   = {r0, r1};
          state_d = DONE;
        end
      end
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      v0_q    <= '0;
      v1_q    <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      key_q   <= '0;
      enc_q   <= 1'b0;
      res_q   <= '0;
    end else if (ena) begin
      state_q <= state_d;
      v0_q    <= v0_d;
      v1_q    <= v1_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      key_q   <= key_d;
      enc_q   <= enc_d;
      res_q   <= res_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == RUN);
  assign out_valid = (state_q == DONE);
  assign out_block = res_q;

endmodule

// File: doc/tea_iter_core.md
# tea_iter_core

Iterative, parametrised TEA block cipher engine for 64-bit blocks and 128-bit keys. It runs a configurable number of rounds, with a configurable number of rounds unrolled per clock. It uses a valid/ready handshake on input and output, and latches key and mode per block. It is the successor to the fully unrolled 32-round datapath and sits between the block framer and the PDF stream buffer, trading throughput for area.

## Interface
Parameters:
- ROUNDS, default 32: total TEA rounds per block (cycles of the Feistel pair); must be ≥1.
- UNROLL, default 1: rounds computed per clock; must divide ROUNDS, otherwise an elaboration error.
- DELTA, default 32'h9E3779B9: key-schedule constant.

Ports (one clock; reset is synchronous and active-high):
- clk, input, 1: clock; all state updates on rising edge.
- rst, input, 1: synchronous active-high reset.
- ena, input, 1: clock enable; when 0, all state is frozen and no handshake completes.
- in_valid, input, 1: in_block/key/encrypt are valid.
- in_ready, output, 1: engine can accept a block.
- encrypt, input, 1: 1 = encrypt, 0 = decrypt; sampled on accept.
- in_block, input, 64: v0 = [63:32], v1 = [31:0].
- key, input, 128: k0 = [127:96], k1 = [95:64], k2 = [63:32], k3 = [31:0]; sampled on accept.
- out_valid, output, 1: out_block holds a finished result.
- out_ready, input, 1: consumer accepts out_block.
- out_block, output, 64: {v0, v1} after the final round (no half swap).
- busy, output, 1: high in RUN.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - On ena & in_valid: latch v0/v1, key, mode.
  - Initial sum: encrypt → 0; decrypt → DELTA*ROUNDS mod 2^32.
  - Clear the round counter; go to RUN.
- RUN: each enabled cycle applies UNROLL rounds combinationally in sequence and increments the counter by 1.
  - Encrypt round, in order:
    - sum += DELTA.
    - v0 += ((v1<<4)+k0) ^ (v1+sum) ^ ((v1>>5)+k1).
    - v1 += ((v0<<4)+k2) ^ (v0+sum) ^ ((v0>>5)+k3), using the new v0.
  - Decrypt round, in order:
    - v1 -= ((v0<<4)+k2) ^ (v0+sum) ^ ((v0>>5)+k3).
    - v0 -= ((v1<<4)+k0) ^ (v1+sum) ^ ((v1>>5)+k1), using the new v1.
    - sum -= DELTA.
  - Arithmetic: all 32-bit modulo 2^32, logical shifts only, and intermediate sums truncated to 32 bits.
  - When the counter reaches ROUNDS/UNROLL-1 on an enabled cycle, the result registers load the final value and the FSM moves to DONE.
  - Counter width: $clog2(ROUNDS/UNROLL)+1 bits.
- DONE:
  - out_valid = 1; out_block is held stable.
  - On ena & out_ready: go to IDLE.
  - in_ready = 0 in DONE (no overlap).
- Inputs changing after accept (key, encrypt, in_block) have no effect on the block in flight.
- The round datapath is shared; there are no per-round registers other than v0, v1, sum, and the counter.

## Timing
- Reset values: state = IDLE, in_ready = 1, out_valid = 0, busy = 0, out_block = 0, counter = 0, sum = 0.
- Accept at rising edge N (ena & in_valid & in_ready). busy is high from N+1; out_valid is high from edge N+ROUNDS/UNROLL (32 cycles at defaults, 8 at UNROLL = 4).
- Output handshake completes at the edge where ena & out_valid & out_ready. in_ready rises after that edge, so the next accept is no earlier than one cycle later. Throughput is one block per ROUNDS/UNROLL+2 cycles.
- out_ready held high while arriving in DONE: one-cycle out_valid pulse.
- ena = 0 in any state: counter, sum, v0/v1, and state hold. Latency stretches by the number of disabled cycles. Outputs keep their current values.
- rst mid-RUN or in DONE: the next edge returns to reset values, the block in flight is discarded, and out_valid never asserts for it. rst has priority over ena.
- in_valid high during RUN/DONE is ignored and not queued.

## Test plan
- ROUNDS=32, UNROLL=1: encrypt, key=0, block=0 → out_block=64'h41EA3A0A_94BAA940, with out_valid exactly 32 cycles after accept.
- Decrypt the previous result with key=0 → out_block=0.
- Key 128'h48756C6B_20697320_7468616C_616D6963: encrypt 64'h25504446_2D312E36, then decrypt the result → the original block. Repeat with UNROLL=4 (latency 8) and UNROLL=32 (latency 1); ciphertexts are identical across UNROLL values.
- Toggle ena low for 5 cycles mid-RUN → result unchanged, latency 37. Hold out_ready=0 for 10 cycles → out_block stable and in_ready=0 throughout.
- Assert rst at cycle 10 of RUN → next cycle shows IDLE/in_ready=1/out_valid=0. A subsequent zero-key block still yields 41EA3A0A_94BAA940.
- Change key/encrypt/in_block every cycle during RUN → output equals the value computed from the accept-time inputs. in_valid held high during RUN → no second accept until after output handshake.
